// File: rtl/pulsegen_core_if.sv
`default_nettype none
// ============================================================================
// Module   : pulsegen_core_if
// Brief    : Control/status bundle for the PWM pulse generator: run enable,
//            period/duty load port and the PWM / end-of-period outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface pulsegen_core_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] duty;
    logic             load;
    logic             pulse;
    logic             cycle_end;

    // Controller side: drives configuration, observes the waveform
    modport master (
        output en,
        output period,
        output duty,
        output load,
        input  pulse,
        input  cycle_end
    );

    // Generator side
    modport slave (
        input  en,
        input  period,
        input  duty,
        input  load,
        output pulse,
        output cycle_end
    );
endinterface : pulsegen_core_if
`default_nettype wire

// File: rtl/pulsegen_core.sv
`default_nettype none
// ============================================================================
// Module   : pulsegen_core
// Brief    : PWM generator with double-buffered period/duty. New settings are
//            loaded into shadow registers and only reach the active registers
//            at a period boundary or while idle, so a running period is never
//            cut short or stretched.
// Revision : 1.0 - initial release
// ============================================================================
module pulsegen_core #(
    parameter int WIDTH          = 16,
    parameter int DEFAULT_PERIOD = 10,
    parameter int DEFAULT_DUTY   = 5
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    pulsegen_core_if.slave bus    // interface WIDTH must equal WIDTH here
);

    localparam logic [WIDTH-1:0] c_def_period = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] c_def_duty   = WIDTH'(DEFAULT_DUTY);
    localparam logic [WIDTH-1:0] c_zero       = '0;
    localparam logic [WIDTH-1:0] c_one        = WIDTH'(1);

    logic             r_run;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_per_act;
    logic [WIDTH-1:0] r_duty_act;
    logic [WIDTH-1:0] r_per_sh;
    logic [WIDTH-1:0] r_duty_sh;
    logic             r_pend;

    logic [WIDTH-1:0] w_last;        // P-1, with a programmed 0 behaving as P=1
    logic             w_at_last;
    logic             w_wrap;
    logic             w_apply_edge;

    // Period of 0 is treated as 1, so the last count is 0 in both cases
    assign w_last       = (r_per_act == c_zero) ? c_zero : (r_per_act - c_one);
    assign w_at_last    = (r_cnt == w_last);
    assign w_wrap       = bus.en & r_run & w_at_last;
    // Safe points to swap settings: the wrap edge, or any edge while idle
    assign w_apply_edge = w_wrap | ~r_run;

    assign bus.pulse     = r_run & (r_cnt < r_duty_act);
    assign bus.cycle_end = r_run & w_at_last;

    // Run tracking and period counter; the first enabled edge only arms r_run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
            r_cnt <= c_zero;
        end else begin
            r_run <= bus.en;
            if (!bus.en || !r_run || w_at_last) begin
                r_cnt <= c_zero;
            end else begin
                r_cnt <= r_cnt + c_one;
            end
        end
    end

    // Shadow capture and deferred hand-over of period/duty to the active set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_per_act  <= c_def_period;
            r_duty_act <= c_def_duty;
            r_per_sh   <= c_def_period;
            r_duty_sh  <= c_def_duty;
            r_pend     <= 1'b0;
        end else if (bus.load) begin
            r_per_sh  <= bus.period;
            r_duty_sh <= bus.duty;
            if (w_apply_edge) begin
                // Fresh values win over any older pending pair
                r_per_act  <= bus.period;
                r_duty_act <= bus.duty;
                r_pend     <= 1'b0;
            end else begin
                r_pend <= 1'b1;
            end
        end else if (r_pend && w_apply_edge) begin
            r_per_act  <= r_per_sh;
            r_duty_act <= r_duty_sh;
            r_pend     <= 1'b0;
        end
    end

endmodule : pulsegen_core
`default_nettype wire

// File: tb/tb_pulsegen_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulsegen_core
// Brief    : Directed self-checking bench for pulsegen_core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulsegen_core;

    localparam int WIDTH = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pulsegen_core_if #(.WIDTH(WIDTH)) bus ();

    pulsegen_core #(
        .WIDTH          (WIDTH),
        .DEFAULT_PERIOD (10),
        .DEFAULT_DUTY   (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge and settle 1 ns past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Program a period/duty pair while idle and leave the generator stopped
    task automatic idle_load(input int p, input int d);
        bus.en = 1'b0;
        step();
        bus.period = WIDTH'(p);
        bus.duty   = WIDTH'(d);
        bus.load   = 1'b1;
        step();
        bus.load = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        bus.en = 1'b1;
        step();
        step();
        if (bus.pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulse: got %b want 0", bus.pulse);
        end
        checks++;
        if (bus.cycle_end !== 1'b0) begin
            errors++;
            $display("FAIL reset_cycle_end: got %b want 0", bus.cycle_end);
        end
        checks++;
        rst_n = 1'b1;
    endtask

    // 10/5 pattern straight out of reset, two full periods
    task automatic test_defaults();
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.pulse !== ((k % 10) < 5)) begin
                errors++;
                $display("FAIL defaults_pulse k=%0d: got %b want %b", k, bus.pulse, (k % 10) < 5);
            end
            checks++;
            if (bus.cycle_end !== ((k % 10) == 9)) begin
                errors++;
                $display("FAIL defaults_cycle_end k=%0d: got %b want %b", k, bus.cycle_end, (k % 10) == 9);
            end
            checks++;
        end
    endtask

    // Load 4/1 at cnt=2; old period must complete, then 1 high / 3 low
    task automatic test_mid_update();
        bit found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            found = bus.cycle_end;
        end
        if (!found) begin
            errors++;
            $display("FAIL mid_update_sync: no cycle_end within 12 clocks");
        end
        checks++;
        step(); step(); step();              // cnt = 2
        bus.period = WIDTH'(4);
        bus.duty   = WIDTH'(1);
        bus.load   = 1'b1;
        step();                              // cnt = 3
        bus.load = 1'b0;
        for (int j = 3; j < 10; j++) begin
            if (j > 3) step();
            if (bus.pulse !== (j < 5) || bus.cycle_end !== (j == 9)) begin
                errors++;
                $display("FAIL mid_update_old j=%0d: got p=%b ce=%b want p=%b ce=%b",
                         j, bus.pulse, bus.cycle_end, j < 5, j == 9);
            end
            checks++;
        end
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.pulse !== ((k % 4) == 0) || bus.cycle_end !== ((k % 4) == 3)) begin
                errors++;
                $display("FAIL mid_update_new k=%0d: got p=%b ce=%b want p=%b ce=%b",
                         k, bus.pulse, bus.cycle_end, (k % 4) == 0, (k % 4) == 3);
            end
            checks++;
        end
    endtask

    task automatic test_duty_zero();
        idle_load(6, 0);
        bus.en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.pulse !== 1'b0 || bus.cycle_end !== ((k % 6) == 5)) begin
                errors++;
                $display("FAIL duty_zero k=%0d: got p=%b ce=%b want p=0 ce=%b",
                         k, bus.pulse, bus.cycle_end, (k % 6) == 5);
            end
            checks++;
        end
    endtask

    task automatic test_duty_over_period();
        idle_load(8, 12);
        bus.en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            if (bus.pulse !== 1'b1 || bus.cycle_end !== ((k % 8) == 7)) begin
                errors++;
                $display("FAIL duty_high k=%0d: got p=%b ce=%b want p=1 ce=%b",
                         k, bus.pulse, bus.cycle_end, (k % 8) == 7);
            end
            checks++;
        end
    endtask

    task automatic test_min_period();
        for (int p = 0; p < 2; p++) begin
            idle_load(p, 1);
            bus.en = 1'b1;
            for (int k = 0; k < 5; k++) begin
                step();
                if (bus.pulse !== 1'b1 || bus.cycle_end !== 1'b1) begin
                    errors++;
                    $display("FAIL min_period P=%0d k=%0d: got p=%b ce=%b want p=1 ce=1",
                             p, k, bus.pulse, bus.cycle_end);
                end
                checks++;
            end
        end
    endtask

    // Two loads before the wrap: only the second (6/3) must take effect
    task automatic test_back_to_back();
        bit found = 1'b0;
        idle_load(10, 5);
        bus.en = 1'b1;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            found = bus.cycle_end;
        end
        if (!found) begin
            errors++;
            $display("FAIL b2b_sync: no cycle_end within 12 clocks");
        end
        checks++;
        step();                              // cnt = 0
        bus.period = WIDTH'(4);
        bus.duty   = WIDTH'(1);
        bus.load   = 1'b1;
        step();                              // cnt = 1
        bus.period = WIDTH'(6);
        bus.duty   = WIDTH'(3);
        step();                              // cnt = 2
        bus.load = 1'b0;
        for (int j = 2; j < 10; j++) begin
            if (j > 2) step();
            if (bus.pulse !== (j < 5) || bus.cycle_end !== (j == 9)) begin
                errors++;
                $display("FAIL b2b_old j=%0d: got p=%b ce=%b want p=%b ce=%b",
                         j, bus.pulse, bus.cycle_end, j < 5, j == 9);
            end
            checks++;
        end
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.pulse !== ((k % 6) < 3) || bus.cycle_end !== ((k % 6) == 5)) begin
                errors++;
                $display("FAIL b2b_new k=%0d: got p=%b ce=%b want p=%b ce=%b",
                         k, bus.pulse, bus.cycle_end, (k % 6) < 3, (k % 6) == 5);
            end
            checks++;
        end
    endtask

    // Pending 4/1, then a 5/2 load landing on the wrap edge: 5/2 applies at once
    task automatic test_load_at_wrap();
        step();                              // cnt = 0 of a 6/3 period
        bus.period = WIDTH'(4);
        bus.duty   = WIDTH'(1);
        bus.load   = 1'b1;
        step();                              // cnt = 1
        bus.load = 1'b0;
        step(); step(); step(); step();      // cnt = 5
        if (bus.cycle_end !== 1'b1) begin
            errors++;
            $display("FAIL wrap_load_sync: cycle_end got %b want 1", bus.cycle_end);
        end
        checks++;
        bus.period = WIDTH'(5);
        bus.duty   = WIDTH'(2);
        bus.load   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            bus.load = 1'b0;
            if (bus.pulse !== ((k % 5) < 2) || bus.cycle_end !== ((k % 5) == 4)) begin
                errors++;
                $display("FAIL wrap_load k=%0d: got p=%b ce=%b want p=%b ce=%b",
                         k, bus.pulse, bus.cycle_end, (k % 5) < 2, (k % 5) == 4);
            end
            checks++;
        end
    endtask

    task automatic test_enable_interrupt();
        idle_load(10, 5);
        bus.en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus.pulse !== 1'b1) begin
                errors++;
                $display("FAIL en_pre k=%0d: pulse got %b want 1", k, bus.pulse);
            end
            checks++;
        end
        bus.en = 1'b0;                       // dropped at cnt = 3
        for (int i = 0; i < 2; i++) begin
            step();
            if (bus.pulse !== 1'b0 || bus.cycle_end !== 1'b0) begin
                errors++;
                $display("FAIL en_off i=%0d: got p=%b ce=%b want p=0 ce=0",
                         i, bus.pulse, bus.cycle_end);
            end
            checks++;
        end
        bus.en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.pulse !== ((k % 10) < 5) || bus.cycle_end !== ((k % 10) == 9)) begin
                errors++;
                $display("FAIL en_resume k=%0d: got p=%b ce=%b want p=%b ce=%b",
                         k, bus.pulse, bus.cycle_end, (k % 10) < 5, (k % 10) == 9);
            end
            checks++;
        end
    endtask

    task automatic test_reset_mid_period();
        step(); step();                      // cnt = 1, pulse high
        if (bus.pulse !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: pulse got %b want 1", bus.pulse);
        end
        checks++;
        #2 rst_n = 1'b0;
        #1;
        if (bus.pulse !== 1'b0 || bus.cycle_end !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: got p=%b ce=%b want p=0 ce=0", bus.pulse, bus.cycle_end);
        end
        checks++;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.pulse !== (k < 5) || bus.cycle_end !== (k == 9)) begin
                errors++;
                $display("FAIL rst_mid_resume k=%0d: got p=%b ce=%b want p=%b ce=%b",
                         k, bus.pulse, bus.cycle_end, k < 5, k == 9);
            end
            checks++;
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        bus.en     = 1'b0;
        bus.load   = 1'b0;
        bus.period = '0;
        bus.duty   = '0;
        test_reset();
        test_defaults();
        test_mid_update();
        test_duty_zero();
        test_duty_over_period();
        test_min_period();
        test_back_to_back();
        test_load_at_wrap();
        test_enable_interrupt();
        test_reset_mid_period();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pulsegen_core
`default_nettype wire
